// File: rtl/apu_req_queue_if.sv
// apu_req_queue_if: bundles the CPU request/response channel, the issue
// channel toward the vector decoder and the completion channel from the
// execution stages. The slave modport is the queue; master is everything
// around it.
interface apu_req_queue_if #(
  parameter int OPERAND_W    = 32,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_W         = 6,
  parameter int FLAGS_IN_W   = 15,
  parameter int FLAGS_OUT_W  = 5,
  parameter int RESULT_W     = 32
);
  // CPU request channel
  logic                                    apu_req;
  logic [NUM_OPERANDS-1:0][OPERAND_W-1:0]  apu_operands;
  logic [OP_W-1:0]                         apu_op;
  logic [FLAGS_IN_W-1:0]                   apu_flags_i;
  logic                                    apu_gnt;

  // CPU response channel
  logic                                    apu_rvalid;
  logic [RESULT_W-1:0]                     apu_result;
  logic [FLAGS_OUT_W-1:0]                  apu_flags_o;

  // Issue channel toward the decoder
  logic                                    iss_valid;
  logic [NUM_OPERANDS-1:0][OPERAND_W-1:0]  iss_operands;
  logic [OP_W-1:0]                         iss_op;
  logic [FLAGS_IN_W-1:0]                   iss_flags;
  logic                                    iss_ready;

  // Completion channel from execution
  logic                                    cmp_valid;
  logic [RESULT_W-1:0]                     cmp_result;
  logic [FLAGS_OUT_W-1:0]                  cmp_flags;

  modport slave (
    input  apu_req, apu_operands, apu_op, apu_flags_i,
    output apu_gnt, apu_rvalid, apu_result, apu_flags_o,
    output iss_valid, iss_operands, iss_op, iss_flags,
    input  iss_ready,
    input  cmp_valid, cmp_result, cmp_flags
  );

  modport master (
    output apu_req, apu_operands, apu_op, apu_flags_i,
    input  apu_gnt, apu_rvalid, apu_result, apu_flags_o,
    input  iss_valid, iss_operands, iss_op, iss_flags,
    output iss_ready,
    output cmp_valid, cmp_result, cmp_flags
  );
endinterface

// File: rtl/apu_req_queue.sv
// apu_req_queue: in-order request queue between the CPU APU port and the
// vector decoder. Requests are admitted only while queued plus in-flight
// entries stay below DEPTH; completions come back as one-cycle apu_rvalid
// strobes. Optional feature: define APU_REQ_QUEUE_BYPASS_EN to let a request
// arriving at an empty queue reach the issue port in the same cycle.
module apu_req_queue #(
  parameter int DEPTH        = 4,
  parameter int OPERAND_W    = 32,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_W         = 6,
  parameter int FLAGS_IN_W   = 15,
  parameter int FLAGS_OUT_W  = 5,
  parameter int RESULT_W     = 32
) (
  input  logic                         clk,
  input  logic                         n_reset,
  apu_req_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         protocol_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [NUM_OPERANDS-1:0][OPERAND_W-1:0] operands_t;

  operands_t               operands_mem [DEPTH];
  logic [OP_W-1:0]         op_mem       [DEPTH];
  logic [FLAGS_IN_W-1:0]   flags_mem    [DEPTH];

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W:0]          credits_used;
  logic                    gnt;
  logic                    queue_nonempty;
  logic                    bypass_active;
  logic                    bypass_take;
  logic                    issue_fire;
  logic                    queue_push;
  logic                    queue_pop;
  logic                    cmp_ok;
  logic                    cmp_err;
  logic                    rvalid_q;
  logic [RESULT_W-1:0]     result_q;
  logic [FLAGS_OUT_W-1:0]  flags_q;

  // A pop moves an entry from queued to in-flight, so it never frees a credit;
  // only a completion does.
  assign credits_used   = {1'b0, occupancy} + {1'b0, inflight};
  assign gnt            = bus.apu_req && (credits_used < (CNT_W+1)'(DEPTH));
  assign queue_nonempty = (occupancy != '0);

`ifdef APU_REQ_QUEUE_BYPASS_EN
  assign bypass_active = !queue_nonempty && gnt;
`else
  assign bypass_active = 1'b0;
`endif

  assign bus.iss_valid = queue_nonempty || bypass_active;
  assign issue_fire    = bus.iss_valid && bus.iss_ready;
  assign bypass_take   = bypass_active && bus.iss_ready;
  assign queue_pop     = queue_nonempty && bus.iss_ready;
  assign queue_push    = gnt && !bypass_take;
  assign cmp_ok        = bus.cmp_valid && (inflight != '0);
  assign cmp_err       = bus.cmp_valid && (inflight == '0);

  assign bus.apu_gnt     = gnt;
  assign bus.apu_rvalid  = rvalid_q;
  assign bus.apu_result  = result_q;
  assign bus.apu_flags_o = flags_q;

  // Issue fields: head entry when queued, the live request when bypassing, else zero.
  always_comb begin
    bus.iss_operands = '0;
    bus.iss_op       = '0;
    bus.iss_flags    = '0;
    if (queue_nonempty) begin
      bus.iss_operands = operands_mem[rd_ptr];
      bus.iss_op       = op_mem[rd_ptr];
      bus.iss_flags    = flags_mem[rd_ptr];
    end
`ifdef APU_REQ_QUEUE_BYPASS_EN
    else if (bypass_active) begin
      bus.iss_operands = bus.apu_operands;
      bus.iss_op       = bus.apu_op;
      bus.iss_flags    = bus.apu_flags_i;
    end
`endif
  end

  // Entry storage is write-only on accept; its contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (queue_push) begin
      operands_mem[wr_ptr] <= bus.apu_operands;
      op_mem[wr_ptr]       <= bus.apu_op;
      flags_mem[wr_ptr]    <= bus.apu_flags_i;
    end
  end

  // Circular-buffer pointers and occupancy count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (queue_push) wr_ptr <= wr_ptr + 1'b1;
      if (queue_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({queue_push, queue_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // In-flight count: up on every issue handshake, down on every legal completion.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      inflight <= '0;
    end else begin
      case ({issue_fire, cmp_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // A completion with nothing in flight is latched as a sticky protocol error.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      protocol_err <= 1'b0;
    end else if (cmp_err) begin
      protocol_err <= 1'b1;
    end
  end

  // Register legal completions into a one-cycle response; data holds between strobes.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rvalid_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      rvalid_q <= cmp_ok;
      if (cmp_ok) begin
        result_q <= bus.cmp_result;
        flags_q  <= bus.cmp_flags;
      end
    end
  end
endmodule

// File: tb/tb_apu_req_queue.sv
// tb_apu_req_queue: directed bench for apu_req_queue. A scoreboard queue holds
// accepted opcodes in order and a response queue holds completions awaiting
// their apu_rvalid strobe. Honours APU_REQ_QUEUE_BYPASS_EN when defined.
module tb_apu_req_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             n_reset = 1'b1;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] inflight;
  logic             protocol_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int rv_seen = 0;

  logic [5:0]  sb_q[$];
  logic [36:0] resp_q[$];
  int          m_infl = 0;
  bit          m_err  = 1'b0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_fl   = '0;

  apu_req_queue_if #(
    .OPERAND_W(32), .NUM_OPERANDS(3), .OP_W(6),
    .FLAGS_IN_W(15), .FLAGS_OUT_W(5), .RESULT_W(32)
  ) bus ();

  apu_req_queue #(
    .DEPTH(DEPTH), .OPERAND_W(32), .NUM_OPERANDS(3), .OP_W(6),
    .FLAGS_IN_W(15), .FLAGS_OUT_W(5), .RESULT_W(32)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus),
    .occupancy(occupancy),
    .inflight(inflight),
    .protocol_err(protocol_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [95:0] mk_operands(input logic [5:0] op);
    return {32'h300 + 32'(op), 32'h200 + 32'(op), 32'h100 + 32'(op)};
  endfunction

  function automatic logic [14:0] mk_flags(input logic [5:0] op);
    return {9'h0a5, op};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_idle();
    bus.apu_req      = 1'b0;
    bus.apu_op       = '0;
    bus.apu_operands = '0;
    bus.apu_flags_i  = '0;
    bus.iss_ready    = 1'b0;
    bus.cmp_valid    = 1'b0;
    bus.cmp_result   = '0;
    bus.cmp_flags    = '0;
  endtask

  // Post-edge checks of registered state against the model
  task automatic check_registered();
    logic [36:0] r;
    check_output("occupancy", 128'(occupancy), 128'(sb_q.size()));
    check_output("inflight", 128'(inflight), 128'(m_infl));
    check_output("protocol_err", 128'(protocol_err), 128'(m_err));
    if (resp_q.size() != 0) begin
      r = resp_q.pop_front();
      m_res = r[36:5];
      m_fl  = r[4:0];
      check_output("apu_rvalid", 128'(bus.apu_rvalid), 128'(1'b1));
    end else begin
      check_output("apu_rvalid", 128'(bus.apu_rvalid), 128'(1'b0));
    end
    check_output("apu_result", 128'(bus.apu_result), 128'(m_res));
    check_output("apu_flags_o", 128'(bus.apu_flags_o), 128'(m_fl));
    if (bus.apu_rvalid === 1'b1) rv_seen++;
  endtask

  // One clock cycle: drive, check combinational outputs, update model, check state
  task automatic apply_stimulus(input bit req, input logic [5:0] op, input bit rdy,
                                input bit cv, input logic [31:0] res, input logic [4:0] fl);
    bit exp_gnt, exp_valid, byp, pop, cv_ok;
    logic [5:0] head;
    @(negedge clk);
    bus.apu_req      = req;
    bus.apu_op       = op;
    bus.apu_operands = mk_operands(op);
    bus.apu_flags_i  = mk_flags(op);
    bus.iss_ready    = rdy;
    bus.cmp_valid    = cv;
    bus.cmp_result   = res;
    bus.cmp_flags    = fl;
    #1;
    exp_gnt = req && ((sb_q.size() + m_infl) < DEPTH);
    byp = 1'b0;
`ifdef APU_REQ_QUEUE_BYPASS_EN
    byp = exp_gnt && (sb_q.size() == 0);
`endif
    exp_valid = (sb_q.size() != 0) || byp;
    head = op;
    if (sb_q.size() != 0) head = sb_q[0];
    check_output("apu_gnt", 128'(bus.apu_gnt), 128'(exp_gnt));
    check_output("iss_valid", 128'(bus.iss_valid), 128'(exp_valid));
    if (exp_valid) begin
      check_output("iss_op", 128'(bus.iss_op), 128'(head));
      check_output("iss_operands", 128'(bus.iss_operands), 128'(mk_operands(head)));
      check_output("iss_flags", 128'(bus.iss_flags), 128'(mk_flags(head)));
    end
    pop   = exp_valid && rdy;
    cv_ok = cv && (m_infl > 0);
    if (cv && m_infl == 0) m_err = 1'b1;
    if (cv_ok) resp_q.push_back({res, fl});
    if (pop && !byp) void'(sb_q.pop_front());
    if (exp_gnt && !(byp && rdy)) sb_q.push_back(op);
    m_infl = m_infl + (pop ? 1 : 0) - (cv_ok ? 1 : 0);
    @(posedge clk);
    #1;
    check_registered();
  endtask

  // Assert reset mid-cycle, check every output is cleared, then release
  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    n_reset = 1'b0;
    #1;
    sb_q.delete();
    resp_q.delete();
    m_infl = 0;
    m_err  = 1'b0;
    m_res  = '0;
    m_fl   = '0;
    check_output("rst_occupancy", 128'(occupancy), 128'(0));
    check_output("rst_inflight", 128'(inflight), 128'(0));
    check_output("rst_protocol_err", 128'(protocol_err), 128'(0));
    check_output("rst_apu_gnt", 128'(bus.apu_gnt), 128'(0));
    check_output("rst_apu_rvalid", 128'(bus.apu_rvalid), 128'(0));
    check_output("rst_apu_result", 128'(bus.apu_result), 128'(0));
    check_output("rst_apu_flags_o", 128'(bus.apu_flags_o), 128'(0));
    check_output("rst_iss_valid", 128'(bus.iss_valid), 128'(0));
    check_output("rst_iss_op", 128'(bus.iss_op), 128'(0));
    check_output("rst_iss_operands", 128'(bus.iss_operands), 128'(0));
    check_output("rst_iss_flags", 128'(bus.iss_flags), 128'(0));
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Directed test sequence
  initial begin
    drive_idle();
    $display("[TB] start");
    reset_dut();

    // Full and credit return: five requests with the decoder stalled
    for (int i = 1; i <= 5; i++) apply_stimulus(1, 6'(i), 0, 0, '0, '0);
    // Release the decoder: 1..4 issue in order, pops free no credit
    for (int i = 0; i < 4; i++) apply_stimulus(1, 6'd5, 1, 0, '0, '0);
    // Completion frees a credit; response latency checked the next cycle
    apply_stimulus(1, 6'd5, 0, 1, 32'hDEADBEEF, 5'h3);
    apply_stimulus(1, 6'd5, 0, 0, '0, '0);
    apply_stimulus(0, 6'd0, 1, 1, 32'h11, 5'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 6'd0, 0, 1, 32'h20 + 32'(i), 5'(i));
    apply_stimulus(0, 6'd0, 0, 0, '0, '0);

    // Wrap-around: ten requests streamed with immediate completions
    rv_seen = 0;
    for (int i = 0; i < 12; i++)
      apply_stimulus(i < 10, 6'(10 + i), 1, i >= 2, 32'h1000 + 32'(i), 5'(i));
    apply_stimulus(0, 6'd0, 0, 0, '0, '0);
    check_output("rvalid_count", 128'(rv_seen), 128'(10));

    // Simultaneous accept + pop + completion at occupancy 2, inflight 1
    apply_stimulus(1, 6'd40, 0, 0, '0, '0);
    apply_stimulus(1, 6'd41, 1, 0, '0, '0);
    apply_stimulus(1, 6'd42, 0, 0, '0, '0);
    check_output("pre_sim_occupancy", 128'(occupancy), 128'(2));
    check_output("pre_sim_inflight", 128'(inflight), 128'(1));
    apply_stimulus(1, 6'd43, 1, 1, 32'h5A5A5A5A, 5'h15);
    check_output("sim_occupancy", 128'(occupancy), 128'(2));
    check_output("sim_inflight", 128'(inflight), 128'(1));

    // Reset mid-run with queued and in-flight work, then a stray completion
    reset_dut();
    apply_stimulus(0, 6'd0, 0, 1, 32'hCAFE0000, 5'h7);
    check_output("stray_protocol_err", 128'(protocol_err), 128'(1));

    // Empty-queue request with the decoder ready (bypass or one-cycle issue)
    apply_stimulus(1, 6'd50, 1, 0, '0, '0);
    apply_stimulus(0, 6'd0, 1, 0, '0, '0);
    apply_stimulus(0, 6'd0, 0, 1, 32'h0BADF00D, 5'h9);
    apply_stimulus(0, 6'd0, 0, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/apu_req_queue.md
# apu_req_queue

Parametrised APU front-end that decouples the CPU's APU request channel from the vector decoder. It accepts requests (operands, op, flags) into a DEPTH-entry in-order queue and issues them to the decoder with a valid/ready handshake. It also registers completion results from the execution stages into single-cycle `apu_rvalid` responses. It enforces a total credit of DEPTH requests (queued plus in-flight) and sits between the CPU APU port and `vector_decoder`.

## Interface
Parameters:
- `DEPTH`, 4: queue entries and total outstanding-request limit; power of two, ≥2
- `OPERAND_W`, 32: width of each operand
- `NUM_OPERANDS`, 3: operands per request
- `OP_W`, 6: width of the APU opcode
- `FLAGS_IN_W`, 15: width of request flags
- `FLAGS_OUT_W`, 5: width of response flags
- `RESULT_W`, 32: width of the response result

Ports:
- `clk`, in, 1: clock; one clock domain
- `n_reset`, in, 1: reset; asynchronous, active-low
- `apu_req`, in, 1: CPU request valid
- `apu_operands`, in, `NUM_OPERANDS` x `OPERAND_W`: request operands
- `apu_op`, in, `OP_W`: request opcode
- `apu_flags_i`, in, `FLAGS_IN_W`: request flags
- `apu_gnt`, out, 1: request accepted this cycle
- `apu_rvalid`, out, 1: single-cycle response strobe
- `apu_result`, out, `RESULT_W`: response result
- `apu_flags_o`, out, `FLAGS_OUT_W`: response flags
- `iss_valid`, out, 1: head entry valid toward the decoder
- `iss_operands`, `iss_op`, `iss_flags`, out: head entry fields, same widths as the request fields
- `iss_ready`, in, 1: decoder takes the head entry
- `cmp_valid`, in, 1: execution completion strobe
- `cmp_result`, in, `RESULT_W`: completion result
- `cmp_flags`, in, `FLAGS_OUT_W`: completion flags
- `occupancy`, out, `$clog2(DEPTH+1)`: queued entries
- `inflight`, out, `$clog2(DEPTH+1)`: issued, not yet completed
- `protocol_err`, out, 1: sticky error flag

## Operation
- **Credit**
  - `apu_gnt = apu_req && (occupancy + inflight < DEPTH)`; combinational.
  - Request fields are captured at the edge where `apu_gnt` is high.
- **Queue**
  - Circular buffer; write and read pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
  - `occupancy` is +1 on accept, −1 on pop (`iss_valid && iss_ready`), and unchanged when both happen.
- **Issue**
  - `iss_valid = (occupancy != 0)`.
  - `iss_*` show the head entry and are held stable while `iss_valid && !iss_ready`.
  - Order is strictly FIFO.
- **In-flight tracking**
  - `inflight` is +1 on pop and −1 on `cmp_valid`; both in the same cycle leaves it unchanged.
- **Response**
  - On `cmp_valid`, the next cycle drives `apu_rvalid = 1` with `apu_result`/`apu_flags_o` equal to the registered `cmp_result`/`cmp_flags`.
  - There is no backpressure on the response path.
  - `apu_result`/`apu_flags_o` hold their last value when `apu_rvalid` is low.
- **Errors**
  - `cmp_valid` while `inflight == 0` is an error: the counter stays at 0, `apu_rvalid` is not raised, and `protocol_err` is set.
  - `protocol_err` clears only on reset.
- **Reset**
  - All outputs and counters go to 0 and pointers go to 0.
  - Reset mid-operation discards queued and in-flight requests; no response is produced for them.

## Timing
- **Accept to `iss_valid`:** 1 cycle; the entry is visible the cycle after the accept edge.
- **Completion to response:** `cmp_valid` in cycle N gives `apu_rvalid` in cycle N+1, exactly one cycle wide per completion.
- **Back-to-back completions:** back-to-back `cmp_valid` produces back-to-back `apu_rvalid`.
- **Full:** with `occupancy + inflight == DEPTH`, `apu_gnt = 0`.
  - A `cmp_valid` in cycle N frees a credit, so `apu_gnt` can rise in cycle N+1.
  - A same-cycle pop does not free a credit.
- **Empty:** `iss_valid = 0`, and `iss_ready` is ignored.
- **Throughput:** 1 accept + 1 issue + 1 completion per cycle sustained.

## Configuration
- `APU_REQ_QUEUE_BYPASS_EN` defined:
  - When `occupancy == 0` and `apu_req && apu_gnt`, the request fields drive `iss_*` combinationally and `iss_valid = 1` in the same cycle.
  - If `iss_ready` is high that cycle, the entry is not written and `inflight` increments directly.
  - Credit rules are unchanged.
- Not defined: no combinational path from the `apu_*` inputs to `iss_*`, and accept-to-issue is always 1 cycle.

## Test plan
- **Reset values:** assert `n_reset` low mid-run with 2 queued and 1 in-flight → all outputs 0 and `occupancy = inflight = 0`; subsequent `cmp_valid` sets `protocol_err = 1` with no `apu_rvalid`.
- **Full and credit return:** DEPTH=4, hold `iss_ready = 0`, present 5 requests with ops 1..5 → `apu_gnt` high for 4 and low for the 5th; `iss_op` sequence after releasing `iss_ready` is 1,2,3,4; pulse `cmp_valid` → 5th granted the cycle after.
- **Wrap-around:** 10 requests with single-cycle `iss_ready` and immediate completions → `iss_op` order preserved across two pointer wraps, and 10 `apu_rvalid` pulses.
- **Response latency:** `cmp_valid` with `cmp_result = 32'hDEADBEEF` and `cmp_flags = 5'h3` in cycle N → `apu_rvalid = 1` with those values in cycle N+1 only.
- **Simultaneous events:** accept + pop + completion in one cycle with occupancy 2 and inflight 1 → occupancy 2 and inflight 1 after the edge.
- **Bypass, `APU_REQ_QUEUE_BYPASS_EN` defined:** empty queue, `apu_req` with `iss_ready = 1` → `iss_valid` in the same cycle and `occupancy` stays 0. Without the macro → `iss_valid` one cycle later.
